// File: rtl/wch_scheduler_pkg.sv
// rtl/wch_scheduler_pkg.sv - layer constants and shared types for the weight-change scheduler
package wch_scheduler_pkg;

    localparam int N1  = 784;
    localparam int N2  = 16;
    localparam int IW  = 10;
    localparam int NW  = 4;
    localparam int LAT = 2;
    localparam int DCW = $clog2(LAT + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SWEEP = 2'd1,
        S_DRAIN = 2'd2
    } wch_state_t;

    // One stage of the write-alignment delay line
    typedef struct packed {
        logic          valid;
        logic [IW-1:0] addr;
        logic [NW-1:0] neuron;
    } wr_slot_t;

endpackage

// File: rtl/wch_scheduler_rr_arbiter.sv
// rtl/wch_scheduler_rr_arbiter.sv - combinational round-robin arbiter, search upward from ptr with wrap
module rr_arbiter #(
    parameter int N = 16,
    parameter int W = 4
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [N-1:0] grant,
    output logic [W-1:0] idx,
    output logic         any_req
);

    always_comb begin
        grant   = '0;
        idx     = '0;
        any_req = 1'b0;
        for (int i = 0; i < N; i++) begin
            int j;
            j = int'(ptr) + i;
            if (j >= N) begin
                j = j - N;
            end
            if (!any_req && req[j]) begin
                any_req  = 1'b1;
                grant[j] = 1'b1;
                idx      = W'(j);
            end
        end
    end

endmodule

// File: rtl/wch_scheduler.sv
// rtl/wch_scheduler.sv - captures weight-change requests, sweeps inputs per granted neuron, aligns weight writes
module wch_scheduler
    import wch_scheduler_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          learn_en,
    input  logic [N2-1:0] wch_req,
    output logic [IW-1:0] ip_select,
    output logic          wr_en,
    output logic [IW-1:0] wr_addr,
    output logic [NW-1:0] wr_neuron,
    output logic          busy,
    output logic          done
);

    wch_state_t     state, state_next;
    logic [N2-1:0]  pending;
    logic [N2-1:0]  arb_grant;
    logic [N2-1:0]  grant_clear;
    logic [NW-1:0]  arb_idx;
    logic           arb_any;
    logic [NW-1:0]  rr_ptr;
    logic [NW-1:0]  cur_neuron;
    logic [DCW-1:0] drain_cnt;
    logic           do_grant;
    logic           last_ip;
    logic           last_drain;
    wr_slot_t       dly [LAT];

    rr_arbiter #(
        .N(N2),
        .W(NW)
    ) u_rr_arbiter (
        .req     (pending),
        .ptr     (rr_ptr),
        .grant   (arb_grant),
        .idx     (arb_idx),
        .any_req (arb_any)
    );

    always_comb begin
        state_next  = state;
        do_grant    = 1'b0;
        grant_clear = '0;
        last_ip     = (ip_select == IW'(N1 - 1));
        last_drain  = (drain_cnt == DCW'(LAT - 1));
        case (state)
            S_IDLE: begin
                if (arb_any) begin
                    do_grant    = 1'b1;
                    grant_clear = arb_grant;
                    state_next  = S_SWEEP;
                end
            end
            S_SWEEP: begin
                if (last_ip) begin
                    state_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (last_drain) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            pending    <= '0;
            rr_ptr     <= '0;
            cur_neuron <= '0;
            ip_select  <= '0;
            drain_cnt  <= '0;
            done       <= 1'b0;
            for (int i = 0; i < LAT; i++) begin
                dly[i] <= '0;
            end
        end else begin
            state <= state_next;
            // A new request beats the grant clear so a same-cycle re-request is not lost
            pending <= (pending & ~grant_clear) | (wch_req & {N2{learn_en}});
            done    <= (state == S_DRAIN) && last_drain;
            if (do_grant) begin
                cur_neuron <= arb_idx;
            end
            if (state == S_SWEEP) begin
                ip_select <= last_ip ? '0 : ip_select + IW'(1);
            end
            drain_cnt <= (state == S_DRAIN && !last_drain) ? drain_cnt + DCW'(1) : '0;
            if (state == S_DRAIN && last_drain) begin
                rr_ptr <= (cur_neuron == NW'(N2 - 1)) ? '0 : cur_neuron + NW'(1);
            end
            dly[0] <= '{valid: (state == S_SWEEP), addr: ip_select, neuron: cur_neuron};
            for (int i = 1; i < LAT; i++) begin
                dly[i] <= dly[i-1];
            end
        end
    end

    assign wr_en     = dly[LAT-1].valid;
    assign wr_addr   = dly[LAT-1].addr;
    assign wr_neuron = dly[LAT-1].neuron;
    assign busy      = (state != S_IDLE);

endmodule

// File: tb/tb_wch_scheduler.sv
// tb/tb_wch_scheduler.sv - directed self-checking bench for wch_scheduler
module tb_wch_scheduler;
    import wch_scheduler_pkg::*;

    logic          clk;
    logic          rst;
    logic          learn_en;
    logic [N2-1:0] wch_req;
    logic [IW-1:0] ip_select;
    logic          wr_en;
    logic [IW-1:0] wr_addr;
    logic [NW-1:0] wr_neuron;
    logic          busy;
    logic          done;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    wch_scheduler dut (
        .clk       (clk),
        .rst       (rst),
        .learn_en  (learn_en),
        .wch_req   (wch_req),
        .ip_select (ip_select),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_neuron (wr_neuron),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_req(input logic [N2-1:0] v, input int n);
        wch_req = v;
        step(n);
        wch_req = '0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        step(2);
        rst = 1'b1;
        step(1);
    endtask

    // Follows one sweep's write burst and reports what it saw; tests judge the results
    task automatic capture_sweep(output int nrn, output int nwr, output int first_cyc,
                                 output bit seq_ok, output bit done_ok, output bit busy_next,
                                 output bit timed_out);
        int guard;
        nrn = -1; nwr = 0; first_cyc = 0; seq_ok = 1'b1;
        done_ok = 1'b0; busy_next = 1'b0; timed_out = 1'b0;
        guard = 0;
        while (wr_en !== 1'b1 && guard < 40) begin
            step(1);
            guard++;
        end
        if (wr_en !== 1'b1) begin
            timed_out = 1'b1;
            return;
        end
        first_cyc = cyc;
        nrn = int'(wr_neuron);
        guard = 0;
        while (wr_en === 1'b1 && guard < N1 + 10) begin
            if (wr_addr !== IW'(nwr) || wr_neuron !== NW'(nrn) || done !== 1'b0 || busy !== 1'b1)
                seq_ok = 1'b0;
            nwr++;
            step(1);
            guard++;
        end
        if (wr_en === 1'b1) timed_out = 1'b1;
        done_ok = (done === 1'b1 && busy === 1'b0);
        step(1);
        busy_next = busy;
        if (done !== 1'b0) done_ok = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0; learn_en = 1'b1; wch_req = '0;
        step(3);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %0b want 0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done: got %0b want 0", done); end
        checks++; if (wr_en !== 1'b0) begin failures++; $display("FAIL reset_wr_en: got %0b want 0", wr_en); end
        checks++; if (ip_select !== '0) begin failures++; $display("FAIL reset_ip_select: got %0d want 0", ip_select); end
        checks++; if (wr_addr !== '0 || wr_neuron !== '0) begin failures++; $display("FAIL reset_wr_fields: got addr %0d neuron %0d want 0 0", wr_addr, wr_neuron); end
        rst = 1'b1;
        step(2);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL idle_after_reset: busy got %0b want 0", busy); end
    endtask

    task automatic test_single();
        int nrn, nwr, fc, req_cyc;
        bit sq, dn, bn, to;
        wch_req = 16'h0004;
        step(1);
        wch_req = '0;
        req_cyc = cyc;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL single_grant_cycle_busy: got %0b want 0", busy); end
        step(1);
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL single_busy: got %0b want 1", busy); end
        checks++; if (ip_select !== '0 || wr_en !== 1'b0) begin failures++; $display("FAIL single_first_sweep: got ip %0d wr_en %0b want 0 0", ip_select, wr_en); end
        step(1);
        checks++; if (ip_select !== IW'(1)) begin failures++; $display("FAIL single_ip_step: got %0d want 1", ip_select); end
        capture_sweep(nrn, nwr, fc, sq, dn, bn, to);
        checks++; if (to) begin failures++; $display("FAIL single_timeout: got timeout want none"); end
        checks++; if (nrn !== 2) begin failures++; $display("FAIL single_neuron: got %0d want 2", nrn); end
        checks++; if (nwr !== N1) begin failures++; $display("FAIL single_writes: got %0d want %0d", nwr, N1); end
        checks++; if (fc - req_cyc !== 3) begin failures++; $display("FAIL single_latency: got %0d want 3", fc - req_cyc); end
        checks++; if (!sq) begin failures++; $display("FAIL single_sequence: got out-of-order want 0..%0d", N1 - 1); end
        checks++; if (!dn) begin failures++; $display("FAIL single_done: got bad done/busy want pulse after last write"); end
        checks++; if (bn !== 1'b0) begin failures++; $display("FAIL single_busy_after: got %0b want 0", bn); end
    endtask

    task automatic test_simultaneous();
        int nrn, nwr, fc;
        bit sq, dn, bn, to;
        int exp_n [3] = '{0, 4, 15};
        do_reset();
        pulse_req(16'h8011, 1);
        for (int k = 0; k < 3; k++) begin
            capture_sweep(nrn, nwr, fc, sq, dn, bn, to);
            checks++; if (to || nrn !== exp_n[k]) begin failures++; $display("FAIL simul_order%0d: got neuron %0d want %0d", k, nrn, exp_n[k]); end
            checks++; if (nwr !== N1 || !sq) begin failures++; $display("FAIL simul_writes%0d: got %0d seq %0b want %0d 1", k, nwr, sq, N1); end
            checks++; if (!dn || bn !== (k < 2)) begin failures++; $display("FAIL simul_gap%0d: got done_ok %0b busy_next %0b want 1 %0b", k, dn, bn, k < 2); end
        end
    endtask

    task automatic test_fairness();
        int nrn, nwr, fc;
        bit sq, dn, bn, to;
        pulse_req(16'h8001, 1);
        capture_sweep(nrn, nwr, fc, sq, dn, bn, to);
        checks++; if (to || nrn !== 0) begin failures++; $display("FAIL fair_first: got %0d want 0", nrn); end
        capture_sweep(nrn, nwr, fc, sq, dn, bn, to);
        checks++; if (to || nrn !== 15 || nwr !== N1) begin failures++; $display("FAIL fair_second: got neuron %0d writes %0d want 15 %0d", nrn, nwr, N1); end
        checks++; if (bn !== 1'b0) begin failures++; $display("FAIL fair_idle: busy got %0b want 0", bn); end
    endtask

    task automatic test_rerequest();
        int nrn, nwr, fc;
        bit sq, dn, bn, to;
        pulse_req(16'h0008, 1);
        fork
            capture_sweep(nrn, nwr, fc, sq, dn, bn, to);
            begin
                step(100);
                pulse_req(16'h0008, 1);
            end
        join
        checks++; if (to || nrn !== 3 || nwr !== N1 || bn !== 1'b1) begin failures++; $display("FAIL rereq_mid_first: got neuron %0d writes %0d busy_next %0b want 3 %0d 1", nrn, nwr, bn, N1); end
        capture_sweep(nrn, nwr, fc, sq, dn, bn, to);
        checks++; if (to || nrn !== 3 || nwr !== N1 || !sq) begin failures++; $display("FAIL rereq_mid_second: got neuron %0d writes %0d want 3 %0d", nrn, nwr, N1); end
        checks++; if (bn !== 1'b0) begin failures++; $display("FAIL rereq_mid_idle: busy got %0b want 0", bn); end
        pulse_req(16'h0008, 2);
        capture_sweep(nrn, nwr, fc, sq, dn, bn, to);
        checks++; if (to || nrn !== 3 || bn !== 1'b1) begin failures++; $display("FAIL rereq_grant_first: got neuron %0d busy_next %0b want 3 1", nrn, bn); end
        capture_sweep(nrn, nwr, fc, sq, dn, bn, to);
        checks++; if (to || nrn !== 3 || nwr !== N1 || bn !== 1'b0) begin failures++; $display("FAIL rereq_grant_second: got neuron %0d writes %0d busy_next %0b want 3 %0d 0", nrn, nwr, bn, N1); end
    endtask

    task automatic test_learn_en();
        int nrn, nwr, fc;
        bit sq, dn, bn, to;
        learn_en = 1'b0;
        pulse_req(16'hFFFF, 1);
        step(3);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL learn_off_busy: got %0b want 0", busy); end
        learn_en = 1'b1;
        pulse_req(16'h0020, 1);
        fork
            capture_sweep(nrn, nwr, fc, sq, dn, bn, to);
            begin
                step(50);
                learn_en = 1'b0;
                pulse_req(16'h0040, 1);
            end
        join
        checks++; if (to || nrn !== 5 || nwr !== N1 || !sq) begin failures++; $display("FAIL learn_mid_sweep: got neuron %0d writes %0d want 5 %0d", nrn, nwr, N1); end
        checks++; if (bn !== 1'b0) begin failures++; $display("FAIL learn_mid_capture: busy got %0b want 0", bn); end
        learn_en = 1'b1;
        step(3);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL learn_no_pending: busy got %0b want 0", busy); end
    endtask

    task automatic test_reset_mid();
        int guard;
        bit saw;
        pulse_req(16'h0002, 1);
        guard = 0;
        while (ip_select !== IW'(400) && guard < 1000) begin
            step(1);
            guard++;
        end
        checks++; if (ip_select !== IW'(400)) begin failures++; $display("FAIL rstmid_reach: got ip %0d want 400", ip_select); end
        #2;
        rst = 1'b0;
        #1;
        checks++; if (busy !== 1'b0 || wr_en !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL rstmid_async_ctrl: got busy %0b wr_en %0b done %0b want 0 0 0", busy, wr_en, done); end
        checks++; if (ip_select !== '0 || wr_addr !== '0 || wr_neuron !== '0) begin failures++; $display("FAIL rstmid_async_data: got ip %0d addr %0d neuron %0d want 0 0 0", ip_select, wr_addr, wr_neuron); end
        step(1);
        rst = 1'b1;
        saw = 1'b0;
        for (int k = 0; k < 10; k++) begin
            step(1);
            if (busy !== 1'b0 || done !== 1'b0) saw = 1'b1;
        end
        checks++; if (saw) begin failures++; $display("FAIL rstmid_after: got busy/done activity want none"); end
    endtask

    initial begin
        rst = 1'b0; learn_en = 1'b1; wch_req = '0;
        test_reset();
        test_single();
        test_simultaneous();
        test_fairness();
        test_rerequest();
        test_learn_en();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/wch_scheduler.md
Name: wch_scheduler

Overview:
- Sequences the weight-change datapath: captures per-output-neuron weight-change requests and arbitrates them round-robin.
- For each granted neuron, sweeps the input-select index over all N1 inputs, one per cycle.
- Emits a weight-memory write strobe and address aligned with the del_w_plus/del_w_minus results from the count-mux/lookup pipeline.
- Sits between the N2 output neurons and the count-mux/lookup datapath plus weight memory in the layer block.

Parameters:
N1, 784, number of inputs per neuron (sweep length)
N2, 16, number of output neurons (requesters)
IW, 10, input index width (must satisfy 2^IW >= N1)
NW, 4, neuron index width (must satisfy 2^NW >= N2)
LAT, 2, cycles from ip_select to valid del_w (count_select register + LUT register)

Ports:
clk  in  1  clock; all state on rising edge
rst  in  1  reset; asynchronous, active-low (asserted when 0)
learn_en  in  1  when 0, new requests are not captured
wch_req  in  N2  per-neuron weight-change request pulses, any number per cycle
ip_select  out  IW  input index driven to the count mux
wr_en  out  1  weight write strobe, aligned with valid del_w
wr_addr  out  IW  input index of the current write (ip_select delayed LAT)
wr_neuron  out  NW  neuron whose weight row is being written
busy  out  1  high in SWEEP or DRAIN
done  out  1  one-cycle pulse after the last write of a sweep

Behaviour:
- Reset (rst=0, async): pending=0, rr_ptr=0, cur_neuron=0, ip_select=0, delay line cleared, state=IDLE. All outputs are 0.
- Pending capture, every cycle: pending <= (pending & ~grant_clear) | (wch_req & {N2{learn_en}}).
  - A request for an already pending neuron merges; no count is kept.
  - A request for the neuron currently being swept sets its pending bit again. It is re-served later.
  - A request arriving in the same cycle as that neuron's grant clear wins: the bit stays set.
- State IDLE: if pending != 0, grant the first set bit searching upward from rr_ptr, wrapping at N2-1 -> 0.
  - Load cur_neuron, clear that pending bit, set ip_select=0, go to SWEEP.
  - Grant takes 1 cycle; ip_select=0 is presented in the first SWEEP cycle.
- State SWEEP: ip_select presented for one cycle each, 0..N1-1.
  - A valid bit with index and neuron enters a LAT-deep shift register each cycle.
  - On the cycle ip_select==N1-1: go to DRAIN and set ip_select to 0 on exit.
- State DRAIN: no new valids enter; lasts LAT cycles until the shift register empties.
  - On the final drain cycle: done=1, rr_ptr <= (cur_neuron+1) mod N2, go to IDLE.
- Write alignment: wr_en/wr_addr/wr_neuron equal the shift register tail. ip_select=k in cycle t gives wr_en=1, wr_addr=k in cycle t+LAT.
  - Exactly N1 writes per grant, contiguous, addresses 0..N1-1 in order.
- Sweep timing: period from grant to return to IDLE is N1+LAT+1 cycles. No overlap between sweeps.
  - ip_select is 0 in IDLE. The datapath reads input 0 harmlessly; wr_en stays low.
- learn_en=0 mid-sweep: the sweep and already-pending requests complete; only capture is gated.
- rst asserted mid-sweep: immediate return to reset state; partial row is abandoned, no done pulse.
- Widths: ip_select counter is IW bits and never exceeds N1-1. rr_ptr and cur_neuron are NW bits; wrap is explicit at N2-1, not a power-of-2 rollover.

Decomposition:
- Shared package/header: N1, N2, IW, NW, LAT defaults alongside the existing layer constants; state encoding localparams (IDLE, SWEEP, DRAIN).
- One sub-module: rr_arbiter. Inputs are the N2 request vector and rr_ptr; outputs are a one-hot grant, encoded index and any_req, all combinational. It is reused by other layer-level schedulers.
- Delay line and FSM stay in wch_scheduler.

Test Plan:
- Single request: pulse wch_req=16'h0004 -> busy next cycle; wr_neuron=2. Exactly 784 wr_en cycles with wr_addr 0..783, first write 3 cycles after the req edge (1 grant + LAT). done pulses one cycle after the last write; busy then drops.
- Simultaneous requests: wch_req=16'h8011 with rr_ptr=0 -> serve order 0, 4, 15. Each gets 784 writes, with done between sweeps and IDLE gaps of 1 cycle.
- Round-robin fairness: after serving neuron 15, requests on 0 and 15 together -> 0 is served first (rr_ptr wrapped to 0), then 15.
- Re-request during own sweep: neuron 3 requests again mid-sweep -> second full sweep of 3 follows. A request for 3 in its grant cycle also yields a re-serve.
- learn_en=0: requests while disabled -> no pending, busy stays 0. A sweep already running completes with all 784 writes.
- Reset mid-sweep: drive rst=0 at ip_select=400 -> all outputs 0 asynchronously, no done. After release with no requests, busy stays 0.
